cpu_run_monitor: RTL and testbench

- Synthesizable run-control and state-dump monitor that sits beside the single-cycle CPU core.
- Snoops PC, instruction, retire strobe and the register-file write port, and keeps a shadow register file.
- On halt-PC, cycle timeout, illegal PC or a periodic checkpoint, it stalls the CPU and streams a dump frame (PC, instr, status, all registers) over a valid/ready interface.
- Halt, timeout and illegal-PC dumps are terminal; periodic checkpoints resume execution.

---
 rtl/cpu_run_monitor.sv | 223 ++++++++++++++++++++++
 tb/tb_cpu_run_monitor.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_monitor.sv
// -----------------------------------------------------------------------------
// cpu_run_monitor
//
// Run-control and state-dump monitor for a single-cycle CPU core. It snoops the
// retiring PC/instruction and the register-file write port, keeps a shadow copy
// of the register file, and on a halt PC, a cycle timeout, an illegal PC or a
// periodic checkpoint it freezes the CPU and streams a dump frame over a
// valid/ready interface. Halt, timeout and illegal-PC dumps end the run;
// periodic checkpoints hand control back to the CPU.
//
// Frame layout (NREG+3 words):
//   w0 = captured PC, w1 = captured instruction,
//   w2 = {cause[1:0], zeros, retire_cnt[CW-1:0]},
//   w3.. = shadow[0..NREG-1]
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   pc_i, instr_i       current CPU PC and instruction
//   retire_i            instruction at pc_i completes this cycle
//   rf_we_i/waddr/wdata CPU register-file write port (snooped)
//   cpu_stall_o         freeze the CPU (high while dumping or done)
//   out_valid_o/ready_i dump stream handshake
//   out_data_o          dump word
//   out_last_o          final word of the frame
//   done_o              run terminated (sticky until reset)
//   cause_o             00 running, 01 halt, 10 timeout, 11 illegal PC
// -----------------------------------------------------------------------------
module cpu_run_monitor #(
  parameter int            DW         = 32,
  parameter int            AW         = 32,
  parameter int            NREG       = 32,
  parameter int            RAW        = 5,
  parameter logic [AW-1:0] HALT_PC    = 'h48,
  parameter int            MAX_CYCLES = 1000,
  parameter int            IMEM_BYTES = 1024,
  parameter int            CHK_PERIOD = 0,
  parameter int            CW         = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [AW-1:0]  pc_i,
  input  logic [DW-1:0]  instr_i,
  input  logic           retire_i,
  input  logic           rf_we_i,
  input  logic [RAW-1:0] rf_waddr_i,
  input  logic [DW-1:0]  rf_wdata_i,
  output logic           cpu_stall_o,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [DW-1:0]  out_data_o,
  output logic           out_last_o,
  output logic           done_o,
  output logic [1:0]     cause_o
);

  localparam int            NWORDS   = NREG + 3;
  localparam int            IW       = $clog2(NWORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DUMP = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_HALT    = 2'b01,
    CAUSE_TIMEOUT = 2'b10,
    CAUSE_ILLEGAL = 2'b11
  } cause_e;

  state_e          state_q,      state_d;
  logic [CW-1:0]   cycle_cnt_q,  cycle_cnt_d;
  logic [CW-1:0]   retire_cnt_q, retire_cnt_d;
  logic [CW-1:0]   chk_cnt_q,    chk_cnt_d;
  logic [IW-1:0]   idx_q,        idx_d;
  logic [AW-1:0]   hdr_pc_q,     hdr_pc_d;
  logic [DW-1:0]   hdr_instr_q,  hdr_instr_d;
  cause_e          hdr_cause_q,  hdr_cause_d;   // cause written into the frame
  cause_e          cause_q,      cause_d;       // cause reported on cause_o
  logic [DW-1:0]   shadow_q [NREG];
  logic [DW-1:0]   shadow_d [NREG];

  // Trigger conditions, only acted on in RUN.
  logic illegal_hit, halt_hit, timeout_hit, chk_hit, any_hit;

  assign illegal_hit = retire_i && ((pc_i[1:0] != 2'b00) || (pc_i >= AW'(IMEM_BYTES)));
  assign halt_hit    = retire_i && (pc_i == HALT_PC);
  assign timeout_hit = (cycle_cnt_q == CW'(MAX_CYCLES - 1));
  assign chk_hit     = (CHK_PERIOD != 0) && retire_i && (chk_cnt_q == CW'(CHK_PERIOD - 1));
  assign any_hit     = illegal_hit || halt_hit || timeout_hit || chk_hit;

  // NOTE: every _d gets a default from its _q first, so no path through the
  // case below can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cycle_cnt_d  = cycle_cnt_q;
    retire_cnt_d = retire_cnt_q;
    chk_cnt_d    = chk_cnt_q;
    idx_d        = idx_q;
    hdr_pc_d     = hdr_pc_q;
    hdr_instr_d  = hdr_instr_q;
    hdr_cause_d  = hdr_cause_q;
    cause_d      = cause_q;
    shadow_d     = shadow_q;

    unique case (state_q)
      ST_RUN: begin
        if (cycle_cnt_q != '1) begin
          cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
        if (retire_i) begin
          retire_cnt_d = retire_cnt_q + 1'b1;
          chk_cnt_d    = chk_cnt_q + 1'b1;
        end
        // r0 is hardwired zero in the core, so its shadow never changes.
        if (rf_we_i && (rf_waddr_i != '0)) begin
          shadow_d[rf_waddr_i] = rf_wdata_i;
        end

        if (any_hit) begin
          hdr_pc_d    = pc_i;
          hdr_instr_d = instr_i;
          idx_d       = '0;
          state_d     = ST_DUMP;
          if (illegal_hit) begin
            hdr_cause_d = CAUSE_ILLEGAL;
          end else if (halt_hit) begin
            hdr_cause_d = CAUSE_HALT;
          end else if (timeout_hit) begin
            hdr_cause_d = CAUSE_TIMEOUT;
          end else begin
            hdr_cause_d = CAUSE_NONE;
            chk_cnt_d   = '0;
          end
          // Checkpoints are not terminal and leave cause_o at "running".
          if (illegal_hit || halt_hit || timeout_hit) begin
            cause_d = hdr_cause_d;
          end
        end
      end

      ST_DUMP: begin
        if (out_ready_i) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = (hdr_cause_q == CAUSE_NONE) ? ST_RUN : ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_DONE;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
      chk_cnt_q    <= '0;
      idx_q        <= '0;
      hdr_pc_q     <= '0;
      hdr_instr_q  <= '0;
      hdr_cause_q  <= CAUSE_NONE;
      cause_q      <= CAUSE_NONE;
      // NOTE: the shadow file is deliberately reset; a dump taken right after
      // reset must show zeros, not whatever the flops powered up with.
      for (int i = 0; i < NREG; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
      chk_cnt_q    <= chk_cnt_d;
      idx_q        <= idx_d;
      hdr_pc_q     <= hdr_pc_d;
      hdr_instr_q  <= hdr_instr_d;
      hdr_cause_q  <= hdr_cause_d;
      cause_q      <= cause_d;
      shadow_q     <= shadow_d;
    end
  end

  // Frame word selection. All sources are registers that cannot change while
  // in DUMP, so the word is stable for as long as the sink stalls.
  logic [DW-1:0] frame_word;

  always_comb begin
    frame_word = '0;
    if (state_q == ST_DUMP) begin
      if (idx_q == IW'(0)) begin
        frame_word = DW'(hdr_pc_q);
      end else if (idx_q == IW'(1)) begin
        frame_word = hdr_instr_q;
      end else if (idx_q == IW'(2)) begin
        frame_word = {hdr_cause_q, {(DW - CW - 2){1'b0}}, retire_cnt_q};
      end else begin
        frame_word = shadow_q[RAW'(idx_q - IW'(3))];
      end
    end
  end

  assign cpu_stall_o = (state_q != ST_RUN);
  assign out_valid_o = (state_q == ST_DUMP);
  assign out_last_o  = (state_q == ST_DUMP) && (idx_q == LAST_IDX);
  assign out_data_o  = frame_word;
  assign done_o      = (state_q == ST_DONE);
  assign cause_o     = cause_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// -----------------------------------------------------------------------------
// tb_cpu_run_monitor
//
// Four monitor instances share one stimulus stream and differ only in their
// parameters: 0 = defaults, 1 = MAX_CYCLES 20, 2 = CHK_PERIOD 4,
// 3 = HALT_PC 0x46 (a misaligned halt address, so halt and illegal coincide).
// "sel" chooses which instance's outputs are observed. Expected dump words are
// built from a small register-file / retire-count model and queued when the
// trigger is driven; they are popped as the DUT transfers words.
// -----------------------------------------------------------------------------
module tb_cpu_run_monitor;

  localparam int NREG   = 32;
  localparam int NWORDS = NREG + 3;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] pc;
    logic [31:0] instr;
    int          fill;        // legal retires before the vector's instruction
    logic [3:0]  ready_pat;   // out_ready pattern, bit (cycle % 4)
    bit          exp_trig;
    logic [1:0]  exp_cause;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic [31:0] instr = '0;
  logic        retire = 1'b0;
  logic        rf_we = 1'b0;
  logic [4:0]  rf_waddr = '0;
  logic [31:0] rf_wdata = '0;
  logic        out_ready = 1'b0;
  logic [1:0]  sel = 2'd0;

  logic [3:0]       stall_v, valid_v, last_v, done_v;
  logic [3:0][31:0] data_v;
  logic [3:0][1:0]  cause_v;

  logic        o_stall, o_valid, o_last, o_done;
  logic [31:0] o_data;
  logic [1:0]  o_cause;

  assign o_stall = stall_v[sel];
  assign o_valid = valid_v[sel];
  assign o_last  = last_v[sel];
  assign o_done  = done_v[sel];
  assign o_data  = data_v[sel];
  assign o_cause = cause_v[sel];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    cpu_run_monitor #(
      .MAX_CYCLES ((g == 1) ? 20 : 1000),
      .CHK_PERIOD ((g == 2) ? 4 : 0),
      .HALT_PC    ((g == 3) ? 32'h46 : 32'h48)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .pc_i        (pc),
      .instr_i     (instr),
      .retire_i    (retire),
      .rf_we_i     (rf_we),
      .rf_waddr_i  (rf_waddr),
      .rf_wdata_i  (rf_wdata),
      .cpu_stall_o (stall_v[g]),
      .out_valid_o (valid_v[g]),
      .out_ready_i (out_ready),
      .out_data_o  (data_v[g]),
      .out_last_o  (last_v[g]),
      .done_o      (done_v[g]),
      .cause_o     (cause_v[g])
    );
  end

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_rf [NREG];
  int          m_retire = 0;
  logic [31:0] sb [$];
  vec_t        vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change at the negedge; outputs are sampled at the following negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) m_rf[i] = '0;
    m_retire = 0;
    sb.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; retire = 1'b0; rf_we = 1'b0; out_ready = 1'b0;
    pc = '0; instr = '0;
    tick();
    tick();
    rst = 1'b0;
    model_clear();
  endtask

  // One CPU cycle while the monitor is in RUN; the model follows the CPU.
  task automatic run_cycle(input logic [31:0] p, input logic [31:0] ins, input logic ret,
                           input logic we, input logic [4:0] wa, input logic [31:0] wd);
    pc = p; instr = ins; retire = ret; rf_we = we; rf_waddr = wa; rf_wdata = wd;
    if (we && wa != 5'd0) m_rf[wa] = wd;
    if (ret) m_retire++;
    tick();
    retire = 1'b0; rf_we = 1'b0;
  endtask

  task automatic push_frame(input logic [31:0] p, input logic [31:0] ins, input logic [1:0] c);
    sb.push_back(p);
    sb.push_back(ins);
    sb.push_back({c, 14'b0, 16'(m_retire)});
    for (int i = 0; i < NREG; i++) sb.push_back(m_rf[i]);
  endtask

  task automatic check_status(input string tag, input logic st, input logic va,
                              input logic dn, input logic [1:0] c);
    check({tag, " stall"}, 32'(o_stall), 32'(st));
    check({tag, " valid"}, 32'(o_valid), 32'(va));
    check({tag, " done"},  32'(o_done),  32'(dn));
    check({tag, " cause"}, 32'(o_cause), 32'(c));
  endtask

  // Drain the queued frame. CPU-side writes and retires are driven throughout
  // and must be ignored by the monitor.
  task automatic collect(input string tag, input logic [3:0] pat);
    int xfers = 0;
    int cyc   = 0;
    int word  = 0;
    while (sb.size() > 0 && cyc < 400) begin
      out_ready = pat[cyc % 4];
      retire = 1'b1; rf_we = 1'b1; rf_waddr = 5'd5; rf_wdata = 32'hDEAD_BEEF;
      check($sformatf("%s valid w%0d", tag, word), 32'(o_valid), 32'd1);
      check($sformatf("%s data w%0d", tag, word), o_data, sb[0]);
      check($sformatf("%s last w%0d", tag, word), 32'(o_last), 32'(sb.size() == 1));
      if (out_ready) begin
        void'(sb.pop_front());
        xfers++;
        word++;
      end
      tick();
      cyc++;
    end
    retire = 1'b0; rf_we = 1'b0; out_ready = 1'b0;
    check({tag, " transfers"}, 32'(xfers), 32'(NWORDS));
    sb.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'd0, 32'h0000_0048, 32'h0800_0012, 17, 4'b1111, 1'b1, 2'b01};
    vecs[1] = '{2'd0, 32'h0000_0046, 32'h0000_0013,  3, 4'b1001, 1'b1, 2'b11};
    vecs[2] = '{2'd0, 32'h0000_0400, 32'h0000_0033,  3, 4'b1111, 1'b1, 2'b11};
    vecs[3] = '{2'd3, 32'h0000_0046, 32'h0000_0073,  3, 4'b0110, 1'b1, 2'b11};
    vecs[4] = '{2'd0, 32'h0000_0010, 32'h0000_0013,  3, 4'b1111, 1'b0, 2'b00};
    vecs[5] = '{2'd0, 32'h0000_03FC, 32'h0000_0013,  3, 4'b1111, 1'b0, 2'b00};
    vecs[6] = '{2'd3, 32'h0000_0048, 32'h0000_0013,  2, 4'b1111, 1'b0, 2'b00};

    // Reset state of every instance.
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      check_status($sformatf("reset%0d", s), 1'b0, 1'b0, 1'b0, 2'b00);
      check($sformatf("reset%0d last", s), 32'(o_last), 32'd0);
      check($sformatf("reset%0d data", s), o_data, 32'd0);
    end

    // Trigger classification vectors. Each writes r7, r31 and r0 during the
    // first filler retires and r3 in the vector's own cycle.
    foreach (vecs[r]) begin
      vec_t  v;
      string tag;
      v   = vecs[r];
      tag = $sformatf("v%0d", r);
      sel = v.sel;
      do_reset();
      for (int k = 0; k < v.fill; k++) begin
        run_cycle(32'(4 * k), 32'h13, 1'b1, k < 3,
                  (k == 0) ? 5'd7 : (k == 1) ? 5'd31 : 5'd0,
                  (k == 0) ? 32'hAB : (k == 1) ? 32'h1234 : 32'hFFFF);
      end
      check({tag, " pre stall"}, 32'(o_stall), 32'd0);
      run_cycle(v.pc, v.instr, 1'b1, 1'b1, 5'd3, 32'hC3C3);
      if (v.exp_trig) begin
        push_frame(v.pc, v.instr, v.exp_cause);
        check_status({tag, " trig"}, 1'b1, 1'b1, 1'b0, v.exp_cause);
        collect(tag, v.ready_pat);
        check_status({tag, " end"}, 1'b1, 1'b0, 1'b1, v.exp_cause);
        run_cycle(32'h0, 32'h13, 1'b1, 1'b0, 5'd0, 32'h0);
        check_status({tag, " sticky"}, 1'b1, 1'b0, 1'b1, v.exp_cause);
      end else begin
        check_status({tag, " notrig"}, 1'b0, 1'b0, 1'b0, 2'b00);
      end
    end

    // Timeout: MAX_CYCLES=20 fires on the 20th edge after reset.
    sel = 2'd1;
    do_reset();
    for (int k = 1; k <= 19; k++) begin
      run_cycle(32'h20, 32'h13, 1'b0, k == 1, 5'd9, 32'h99);
    end
    check_status("tmo pre", 1'b0, 1'b0, 1'b0, 2'b00);
    run_cycle(32'h24, 32'h0000_0013, 1'b0, 1'b0, 5'd0, 32'h0);
    push_frame(32'h24, 32'h0000_0013, 2'b10);
    check_status("tmo trig", 1'b1, 1'b1, 1'b0, 2'b10);
    collect("tmo", 4'b1111);
    check_status("tmo end", 1'b1, 1'b0, 1'b1, 2'b10);

    // Periodic checkpoints every 4 retires; execution resumes after each.
    sel = 2'd2;
    do_reset();
    for (int f = 0; f < 2; f++) begin
      string tag;
      tag = $sformatf("chk%0d", f);
      for (int k = 0; k < 3; k++) begin
        run_cycle(32'(16 * f + 4 * k), 32'h13, 1'b1, f == 0 && k == 0, 5'd5, 32'h55);
        check($sformatf("%s run stall %0d", tag, k), 32'(o_stall), 32'd0);
      end
      run_cycle(32'(16 * f + 12), 32'h0000_1013, 1'b1, 1'b0, 5'd0, 32'h0);
      push_frame(32'(16 * f + 12), 32'h0000_1013, 2'b00);
      check_status({tag, " trig"}, 1'b1, 1'b1, 1'b0, 2'b00);
      collect(tag, 4'b1001);
      check_status({tag, " resume"}, 1'b0, 1'b0, 1'b0, 2'b00);
    end

    // Reset while word 10 of a dump is on the bus; shadow file is cleared.
    sel = 2'd0;
    do_reset();
    run_cycle(32'h0, 32'h13, 1'b1, 1'b1, 5'd7, 32'hAB);
    run_cycle(32'h48, 32'h0800_0012, 1'b1, 1'b0, 5'd0, 32'h0);
    push_frame(32'h48, 32'h0800_0012, 2'b01);
    out_ready = 1'b1;
    for (int w = 0; w < 10; w++) begin
      void'(sb.pop_front());
      tick();
    end
    out_ready = 1'b0;
    check("abort w10 data", o_data, sb[0]);
    rst = 1'b1;
    #1;
    check_status("abort async", 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    check_status("abort next", 1'b0, 1'b0, 1'b0, 2'b00);
    rst = 1'b0;
    model_clear();
    run_cycle(32'h0, 32'h13, 1'b1, 1'b1, 5'd0, 32'hFFFF);
    run_cycle(32'h48, 32'h0800_0012, 1'b1, 1'b0, 5'd0, 32'h0);
    push_frame(32'h48, 32'h0800_0012, 2'b01);
    collect("after_abort", 4'b1111);
    check_status("after_abort end", 1'b1, 1'b0, 1'b1, 2'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
